// File: rtl/drop_indicator_ctrl.sv
// drop_indicator_ctrl
// Sequences the top-row drop indicator of the Connect 4 display. It tracks the
// selected column and whose turn it is. It issues one drop request per move to
// the board logic over a req/ack handshake. It also drives the indicator sprite
// offset and its visibility.
//
// Ports
//   clk              system clock
//   rst              synchronous reset, active-high
//   btnLeft          pulse, move selection left (wraps)
//   btnRight         pulse, move selection right (wraps)
//   btnDrop          pulse, drop a piece in the selected column
//   colFull          bit i set = column i cannot accept a piece
//   dropAck          board accepted the drop request (pulse)
//   gameOver         level, board detected a win or draw
//   column           selected column
//   indicatorX       COL_X0 + column*COL_PITCH
//   redTurn          1 = red to move, 0 = yellow to move
//   indicatorVisible indicator sprite enable
//   dropReq          drop request to board
//   dropCol          requested column, stable while dropReq = 1
//
// state  | meaning
// SELECT | player moves the indicator and may request a drop
// REQ    | waiting for dropAck; indicator hidden, buttons ignored
// SWAP   | one cycle; hand the turn to the other player
// DONE   | game over; everything frozen until rst
module drop_indicator_ctrl #(
  parameter int NUM_COLS  = 7,
  parameter int COL_X0    = 24,
  parameter int COL_PITCH = 16,
  parameter int START_COL = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btnLeft,
  input  logic                btnRight,
  input  logic                btnDrop,
  input  logic [NUM_COLS-1:0] colFull,
  input  logic                dropAck,
  input  logic                gameOver,
  output logic [2:0]          column,
  output logic [9:0]          indicatorX,
  output logic                redTurn,
  output logic                indicatorVisible,
  output logic                dropReq,
  output logic [2:0]          dropCol
);

  localparam logic [1:0] SELECT = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] SWAP   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [2:0] LAST_COL  = 3'(NUM_COLS - 1);
  localparam logic [2:0] RST_COL   = 3'(START_COL);
  localparam logic [9:0] RST_X     = 10'(COL_X0 + START_COL * COL_PITCH);

  logic [1:0] r_state;
  logic [2:0] r_column;
  logic [9:0] r_x;
  logic       r_red;
  logic       r_vis;
  logic       r_req;
  logic [2:0] r_dcol;

  logic [2:0] w_next_col;
  logic [9:0] w_next_x;
  logic       w_sel_full;

  assign w_sel_full = colFull[r_column];

  // Opposite pulses in the same cycle cancel out.
  always_comb begin
    w_next_col = r_column;
    if (btnLeft && !btnRight) begin
      w_next_col = (r_column == 3'd0) ? LAST_COL : r_column - 3'd1;
    end else if (btnRight && !btnLeft) begin
      w_next_col = (r_column == LAST_COL) ? 3'd0 : r_column + 3'd1;
    end
  end

  assign w_next_x = 10'(COL_X0) + 10'(w_next_col) * 10'(COL_PITCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SELECT;
      r_column <= RST_COL;
      r_x      <= RST_X;
      r_red    <= 1'b1;
      r_vis    <= 1'b1;
      r_req    <= 1'b0;
      r_dcol   <= 3'd0;
    end else begin
      case (r_state)
        SELECT: begin
          if (gameOver) begin
            r_state <= DONE;
            r_vis   <= 1'b0;
            r_req   <= 1'b0;
          end else if (btnDrop && !w_sel_full) begin
            r_state <= REQ;
            r_dcol  <= r_column;
            r_req   <= 1'b1;
            r_vis   <= 1'b0;
          end else begin
            // A drop on a full column is dropped silently, so moves still apply.
            r_column <= w_next_col;
            r_x      <= w_next_x;
          end
        end
        REQ: begin
          // gameOver alone does not abort; only the ack cycle decides.
          if (dropAck) begin
            r_req   <= 1'b0;
            r_state <= gameOver ? DONE : SWAP;
          end
        end
        SWAP: begin
          r_red   <= ~r_red;
          r_vis   <= 1'b1;
          r_state <= SELECT;
        end
        default: begin
          r_vis <= 1'b0;
          r_req <= 1'b0;
        end
      endcase
    end
  end

  assign column           = r_column;
  assign indicatorX       = r_x;
  assign redTurn          = r_red;
  assign indicatorVisible = r_vis;
  assign dropReq          = r_req;
  assign dropCol          = r_dcol;

endmodule

// File: tb/tb_drop_indicator_ctrl.sv
// tb_drop_indicator_ctrl
// Directed bench for drop_indicator_ctrl with the default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_drop_indicator_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnLeft = 1'b0;
  logic       btnRight = 1'b0;
  logic       btnDrop = 1'b0;
  logic [6:0] colFull = 7'd0;
  logic       dropAck = 1'b0;
  logic       gameOver = 1'b0;
  logic [2:0] column;
  logic [9:0] indicatorX;
  logic       redTurn;
  logic       indicatorVisible;
  logic       dropReq;
  logic [2:0] dropCol;

  int n_cmp = 0;
  int n_err = 0;

  drop_indicator_ctrl dut (
    .clk(clk), .rst(rst), .btnLeft(btnLeft), .btnRight(btnRight),
    .btnDrop(btnDrop), .colFull(colFull), .dropAck(dropAck),
    .gameOver(gameOver), .column(column), .indicatorX(indicatorX),
    .redTurn(redTurn), .indicatorVisible(indicatorVisible),
    .dropReq(dropReq), .dropCol(dropCol)
  );

  always #5 clk = ~clk;

  // One edge with the currently driven inputs; pulse inputs are cleared after.
  task automatic tick();
    @(posedge clk);
    #1;
    btnLeft  = 1'b0;
    btnRight = 1'b0;
    btnDrop  = 1'b0;
    dropAck  = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    repeat (5) tick();
    n_cmp++; if (column !== 3'd3) begin n_err++; $display("FAIL reset_column got %0d want 3", column); end
    n_cmp++; if (indicatorX !== 10'd72) begin n_err++; $display("FAIL reset_x got %0d want 72", indicatorX); end
    n_cmp++; if (redTurn !== 1'b1) begin n_err++; $display("FAIL reset_red got %b want 1", redTurn); end
    n_cmp++; if (indicatorVisible !== 1'b1) begin n_err++; $display("FAIL reset_vis got %b want 1", indicatorVisible); end
    n_cmp++; if (dropReq !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", dropReq); end
    n_cmp++; if (dropCol !== 3'd0) begin n_err++; $display("FAIL reset_dcol got %0d want 0", dropCol); end
  endtask

  task automatic test_move();
    logic [2:0] exp_col [4];
    logic [9:0] exp_x [4];
    exp_col = '{3'd4, 3'd5, 3'd6, 3'd0};
    exp_x   = '{10'd88, 10'd104, 10'd120, 10'd24};
    for (int i = 0; i < 4; i++) begin
      btnRight = 1'b1;
      tick();
      n_cmp++; if (column !== exp_col[i]) begin n_err++; $display("FAIL move_right%0d_col got %0d want %0d", i, column, exp_col[i]); end
      n_cmp++; if (indicatorX !== exp_x[i]) begin n_err++; $display("FAIL move_right%0d_x got %0d want %0d", i, indicatorX, exp_x[i]); end
    end
    btnLeft = 1'b1;
    tick();
    n_cmp++; if (column !== 3'd6) begin n_err++; $display("FAIL wrap_left_col got %0d want 6", column); end
    n_cmp++; if (indicatorX !== 10'd120) begin n_err++; $display("FAIL wrap_left_x got %0d want 120", indicatorX); end
    btnLeft = 1'b1; btnRight = 1'b1;
    tick();
    n_cmp++; if (column !== 3'd6) begin n_err++; $display("FAIL both_btn_col got %0d want 6", column); end
  endtask

  task automatic test_drop_hold();
    rst = 1'b1;
    tick();
    btnDrop = 1'b1;
    tick();
    n_cmp++; if (dropReq !== 1'b1) begin n_err++; $display("FAIL drop_req got %b want 1", dropReq); end
    for (int i = 0; i < 10; i++) begin
      btnLeft = 1'b1;
      tick();
      n_cmp++; if (dropReq !== 1'b1) begin n_err++; $display("FAIL hold%0d_req got %b want 1", i, dropReq); end
      n_cmp++; if (dropCol !== 3'd3) begin n_err++; $display("FAIL hold%0d_dcol got %0d want 3", i, dropCol); end
      n_cmp++; if (column !== 3'd3) begin n_err++; $display("FAIL hold%0d_col got %0d want 3", i, column); end
      n_cmp++; if (indicatorVisible !== 1'b0) begin n_err++; $display("FAIL hold%0d_vis got %b want 0", i, indicatorVisible); end
    end
    dropAck = 1'b1;
    tick();
    n_cmp++; if (dropReq !== 1'b0) begin n_err++; $display("FAIL ack_req got %b want 0", dropReq); end
    n_cmp++; if (redTurn !== 1'b1) begin n_err++; $display("FAIL ack_red_early got %b want 1", redTurn); end
    tick();
    n_cmp++; if (redTurn !== 1'b0) begin n_err++; $display("FAIL swap_red got %b want 0", redTurn); end
    n_cmp++; if (indicatorVisible !== 1'b1) begin n_err++; $display("FAIL swap_vis got %b want 1", indicatorVisible); end
    btnRight = 1'b1;
    tick();
    n_cmp++; if (column !== 3'd4) begin n_err++; $display("FAIL select_again_col got %0d want 4", column); end
  endtask

  task automatic test_full_column();
    btnLeft = 1'b1;
    tick();
    colFull = 7'b0001000;
    btnDrop = 1'b1; btnRight = 1'b1;
    tick();
    n_cmp++; if (dropReq !== 1'b0) begin n_err++; $display("FAIL full_req got %b want 0", dropReq); end
    n_cmp++; if (column !== 3'd4) begin n_err++; $display("FAIL full_col got %0d want 4", column); end
    n_cmp++; if (indicatorVisible !== 1'b1) begin n_err++; $display("FAIL full_vis got %b want 1", indicatorVisible); end
    btnDrop = 1'b1;
    tick();
    n_cmp++; if (dropReq !== 1'b1) begin n_err++; $display("FAIL full_next_req got %b want 1", dropReq); end
    n_cmp++; if (dropCol !== 3'd4) begin n_err++; $display("FAIL full_next_dcol got %0d want 4", dropCol); end
    colFull = 7'd0;
  endtask

  task automatic test_game_over();
    gameOver = 1'b1; dropAck = 1'b1;
    tick();
    tick();
    n_cmp++; if (redTurn !== 1'b0) begin n_err++; $display("FAIL over_red got %b want 0", redTurn); end
    n_cmp++; if (indicatorVisible !== 1'b0) begin n_err++; $display("FAIL over_vis got %b want 0", indicatorVisible); end
    n_cmp++; if (dropReq !== 1'b0) begin n_err++; $display("FAIL over_req got %b want 0", dropReq); end
    gameOver = 1'b0;
    btnRight = 1'b1; tick();
    btnDrop = 1'b1; tick();
    btnLeft = 1'b1; tick();
    tick();
    n_cmp++; if (column !== 3'd4) begin n_err++; $display("FAIL frozen_col got %0d want 4", column); end
    n_cmp++; if (dropReq !== 1'b0) begin n_err++; $display("FAIL frozen_req got %b want 0", dropReq); end
    n_cmp++; if (indicatorVisible !== 1'b0) begin n_err++; $display("FAIL frozen_vis got %b want 0", indicatorVisible); end
    n_cmp++; if (redTurn !== 1'b0) begin n_err++; $display("FAIL frozen_red got %b want 0", redTurn); end
    rst = 1'b1;
    tick();
    n_cmp++; if (column !== 3'd3) begin n_err++; $display("FAIL rerst_col got %0d want 3", column); end
    n_cmp++; if (indicatorX !== 10'd72) begin n_err++; $display("FAIL rerst_x got %0d want 72", indicatorX); end
    n_cmp++; if (redTurn !== 1'b1) begin n_err++; $display("FAIL rerst_red got %b want 1", redTurn); end
    n_cmp++; if (indicatorVisible !== 1'b1) begin n_err++; $display("FAIL rerst_vis got %b want 1", indicatorVisible); end
  endtask

  task automatic test_rst_mid_req();
    btnRight = 1'b1; tick();
    btnDrop = 1'b1; tick();
    n_cmp++; if (dropReq !== 1'b1) begin n_err++; $display("FAIL mid_req_set got %b want 1", dropReq); end
    n_cmp++; if (dropCol !== 3'd4) begin n_err++; $display("FAIL mid_dcol got %0d want 4", dropCol); end
    rst = 1'b1;
    tick();
    n_cmp++; if (dropReq !== 1'b0) begin n_err++; $display("FAIL mid_rst_req got %b want 0", dropReq); end
    n_cmp++; if (column !== 3'd3) begin n_err++; $display("FAIL mid_rst_col got %0d want 3", column); end
    dropAck = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (redTurn !== 1'b1) begin n_err++; $display("FAIL stray_ack_red got %b want 1", redTurn); end
    n_cmp++; if (indicatorVisible !== 1'b1) begin n_err++; $display("FAIL stray_ack_vis got %b want 1", indicatorVisible); end
    n_cmp++; if (dropReq !== 1'b0) begin n_err++; $display("FAIL stray_ack_req got %b want 0", dropReq); end
    btnLeft = 1'b1;
    tick();
    n_cmp++; if (column !== 3'd2) begin n_err++; $display("FAIL post_rst_move got %0d want 2", column); end
  endtask

  task automatic test_over_in_select();
    gameOver = 1'b1; btnDrop = 1'b1;
    tick();
    gameOver = 1'b0;
    n_cmp++; if (dropReq !== 1'b0) begin n_err++; $display("FAIL sel_over_req got %b want 0", dropReq); end
    n_cmp++; if (indicatorVisible !== 1'b0) begin n_err++; $display("FAIL sel_over_vis got %b want 0", indicatorVisible); end
    btnRight = 1'b1;
    tick();
    n_cmp++; if (column !== 3'd2) begin n_err++; $display("FAIL sel_over_col got %0d want 2", column); end
  endtask

  initial begin
    #1;
    test_reset();
    test_move();
    test_drop_hold();
    test_full_column();
    test_game_over();
    test_rst_mid_req();
    test_over_in_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/drop_indicator_ctrl.md
Name: drop_indicator_ctrl

Overview:
- Sequences the top-row drop indicator for the Connect 4 display: tracks the selected column and whose turn it is, and issues one drop request per move to the board-state logic through a req/ack handshake.
- Drives the horizontal offset and visibility consumed by the red/yellow indicator sprite modules on the 160x120 canvas.
- Sits between the debounced button pulse logic and the board/renderer.

Parameters:
- NUM_COLS, 7, number of board columns; legal range 2..8 because the column index is 3 bits.
- COL_X0, 24, canvas x (pixels) of the indicator's left edge at column 0.
- COL_PITCH, 16, canvas x distance (pixels) between adjacent columns.
- START_COL, 3, column selected after reset; must be < NUM_COLS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btnLeft  in  1  single-cycle pulse, move selection left
- btnRight  in  1  single-cycle pulse, move selection right
- btnDrop  in  1  single-cycle pulse, drop a piece in the selected column
- colFull  in  NUM_COLS  bit i = 1 means column i cannot accept a piece
- dropAck  in  1  board has accepted the drop request (one-cycle pulse)
- gameOver  in  1  level; board has detected a win or draw
- column  out  3  currently selected column
- indicatorX  out  10  COL_X0 + column*COL_PITCH
- redTurn  out  1  1 = red to move, 0 = yellow to move
- indicatorVisible  out  1  indicator sprite enable
- dropReq  out  1  drop request to board
- dropCol  out  3  column being requested; stable while dropReq = 1

Behaviour:
- Clock, reset and interface: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values, applied at the first clk edge with rst = 1 and taking priority over every other input:
  - state = SELECT
  - column = START_COL
  - indicatorX = COL_X0 + START_COL*COL_PITCH
  - redTurn = 1, indicatorVisible = 1, dropReq = 0, dropCol = 0
  - rst asserted mid-request drops dropReq with no ack required.
- States: SELECT, REQ, SWAP, DONE. All outputs are registered.
- SELECT, evaluated in this priority order:
  - gameOver = 1: go to DONE.
  - btnDrop = 1 and colFull[column] = 0: latch dropCol = column, set dropReq = 1, go to REQ. Left/right pulses in the same cycle are ignored.
  - btnDrop = 1 and colFull[column] = 1: drop ignored, stay in SELECT; left/right in that cycle are still evaluated.
  - btnLeft XOR btnRight: column moves by one with wrap-around. Left from 0 goes to NUM_COLS-1; right from NUM_COLS-1 goes to 0. Full columns are not skipped.
  - btnLeft and btnRight both 1: no move.
- REQ:
  - dropReq stays 1 and dropCol stays constant until dropAck.
  - On dropAck: dropReq = 0 in the next cycle. If gameOver = 1 in the ack cycle, go to DONE; otherwise go to SWAP.
  - Buttons are ignored. gameOver without dropAck does not abort the request.
  - indicatorVisible = 0 while in REQ.
- SWAP: lasts one cycle. Toggles redTurn, sets indicatorVisible = 1, returns to SELECT. column is unchanged. Buttons are ignored.
- DONE:
  - indicatorVisible = 0, dropReq = 0, redTurn frozen.
  - Buttons are ignored. Exits only via rst.
- indicatorX: registered, updated in the same edge as column, computed as a 10-bit unsigned value. With the defaults, column 6 gives 24 + 96 = 120.
- Move latency: a button pulse at edge n is reflected in column and indicatorX after edge n.
- Drop latency: a btnDrop at edge n gives dropReq = 1 after edge n.
- After dropAck at edge m: state = SWAP after edge m, redTurn toggled and state = SELECT after edge m+1. Minimum 3 cycles per move.
- dropAck while not in REQ: ignored.

Test Plan:
- Reset then idle 5 cycles -> column = 3, indicatorX = 72, redTurn = 1, indicatorVisible = 1, dropReq = 0.
- Four btnRight pulses from reset -> columns 4, 5, 6, 0 (indicatorX 88, 104, 120, 24); then one btnLeft -> column 6; btnLeft + btnRight in the same cycle -> column stays 6.
- btnDrop at column 3 with colFull = 0, dropAck held off 10 cycles while pulsing btnLeft -> dropReq = 1 and dropCol = 3 throughout, column stays 3, indicatorVisible = 0. Then dropAck -> dropReq = 0, redTurn = 0 two edges after the ack, back in SELECT.
- colFull = 7'b0001000 at column 3, btnDrop + btnRight in the same cycle -> no dropReq, column = 4. Then btnDrop -> dropReq = 1 with dropCol = 4.
- gameOver = 1 together with dropAck -> no redTurn toggle, indicatorVisible = 0. Subsequent buttons produce no change until rst, after which reset values return.
- rst pulsed while dropReq = 1 -> dropReq = 0 and column = 3 after that edge; a later dropAck is ignored.
